// File: rtl/hdmi_src_pkg.sv
// Shared types for the HDMI source scheduler: source/state encodings, colour-bar palette
// and the source rotation order.
package hdmi_src_pkg;

   typedef enum logic [1:0] {SRC_NOISE, SRC_CONSOLE, SRC_BARS} src_t;
   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   localparam logic [23:0] BAR_COLOUR [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   function automatic src_t next_src(input src_t s);
      case (s)
         SRC_NOISE:   return SRC_CONSOLE;
         SRC_CONSOLE: return SRC_BARS;
         default:     return SRC_NOISE;
      endcase
   endfunction

endpackage

// File: rtl/hdmi_source_scheduler_if.sv
// Pixel-side bundle between raster/sources and the scheduler; the scheduler is the slave.
// Unregistered wires only; no flow control, one pixel per clk_pixel.
interface hdmi_source_scheduler_if;
   logic        locked;
   logic        btn_next;
   logic [9:0]  cx;
   logic [9:0]  cy;
   logic [23:0] noise_rgb;
   logic [23:0] console_rgb;
   logic [23:0] rgb;
   logic [1:0]  source_sel;
   logic [7:0]  codepoint;
   logic        frame_start;

   modport master (
      output locked, btn_next, cx, cy, noise_rgb, console_rgb,
      input  rgb, source_sel, codepoint, frame_start
   );

   modport slave (
      input  locked, btn_next, cx, cy, noise_rgb, console_rgb,
      output rgb, source_sel, codepoint, frame_start
   );
endinterface

// File: rtl/btn_debounce.sv
// Button synchroniser + stability counter; one-cycle pulse once input held high DEBOUNCE_CYCLES.
// Latency: 2 sync stages plus DEBOUNCE_CYCLES; no backpressure, a long hold yields one pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 742500
) (
   input  logic clk_pixel,
   input  logic rst,
   input  logic btn,
   output logic pulse
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] ARM  = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         // Counter saturates at FULL so a held button fires exactly once.
         if (!sync2)
            cnt <= '0;
         else if (cnt != FULL)
            cnt <= cnt + 1'b1;
         pulse <= sync2 && (cnt == ARM);
      end
   end
endmodule

// File: rtl/hdmi_source_scheduler.sv
// Per-frame pixel source selection (noise/console/bars) with timer or button advance.
// Latency: rgb is one clk_pixel behind cx/cy; no backpressure, the raster free-runs.
module hdmi_source_scheduler
   import hdmi_src_pkg::*;
#(
   parameter int SCREEN_WIDTH    = 1280,
   parameter int SCREEN_HEIGHT   = 720,
   parameter int DWELL_FRAMES    = 300,
   parameter int DEBOUNCE_CYCLES = 742500
) (
   input logic                      clk_pixel,
   input logic                      rst,
   hdmi_source_scheduler_if.slave   bus
);
   localparam int DW_W = $clog2(DWELL_FRAMES + 1);
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
   localparam logic [9:0] WIDTH10  = 10'(SCREEN_WIDTH);
   localparam logic [9:0] HEIGHT10 = 10'(SCREEN_HEIGHT);
   localparam logic [9:0] BAR_W10  = 10'(SCREEN_WIDTH / 8);

   state_t          state;
   src_t            sel;
   logic [DW_W-1:0] dwell;
   logic            pending;
   logic            press;
   logic [23:0]     rgb_q;
   logic            fs_q;
   logic [7:0]      cp;
   logic [5:0]      prev_row;
   logic            fb;
   logic            active;
   logic [2:0]      bar_idx;
   logic [23:0]     pix;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk_pixel (clk_pixel),
      .rst       (rst),
      .btn       (bus.btn_next),
      .pulse     (press)
   );

   assign fb      = (bus.cx == 10'd0) && (bus.cy == 10'd0);
   assign active  = (bus.cx < WIDTH10) && (bus.cy < HEIGHT10);
   assign bar_idx = 3'(bus.cx / BAR_W10);

   // Losing lock blanks the very next pixel, ahead of the state register catching up.
   always_comb begin
      pix = 24'h0;
      if (state == ST_SHOW && bus.locked && active) begin
         case (sel)
            SRC_NOISE:   pix = bus.noise_rgb;
            SRC_CONSOLE: pix = bus.console_rgb;
            SRC_BARS:    pix = BAR_COLOUR[bar_idx];
            default:     pix = 24'h0;
         endcase
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         state    <= ST_BLANK;
         sel      <= SRC_NOISE;
         dwell    <= '0;
         pending  <= 1'b0;
         rgb_q    <= 24'h0;
         fs_q     <= 1'b0;
         cp       <= 8'h30;
         prev_row <= 6'd0;
      end else begin
         rgb_q <= pix;
         fs_q  <= fb;

         if (bus.cy == 10'd0) begin
            cp       <= 8'h30;
            prev_row <= 6'd0;
         end else if (bus.cy[9:4] != prev_row) begin
            cp       <= cp + 8'd1;
            prev_row <= bus.cy[9:4];
         end

         if (state == ST_BLANK) begin
            if (fb && bus.locked)
               state <= ST_SHOW;
         end else begin
            if (!bus.locked) begin
               state   <= ST_BLANK;
               dwell   <= '0;
               pending <= 1'b0;
            end else if (fb) begin
               // A press landing on the boundary itself merges with pending/expiry.
               if (pending || press || dwell == DWELL_LAST) begin
                  sel     <= next_src(sel);
                  dwell   <= '0;
                  pending <= 1'b0;
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end else if (press) begin
               pending <= 1'b1;
            end
         end
      end
   end

   assign bus.rgb         = rgb_q;
   assign bus.source_sel  = sel;
   assign bus.codepoint   = cp;
   assign bus.frame_start = fs_q;
endmodule
